// File: rtl/matrix_ctrl_pkg.sv
// Shared state encoding, datapath widths and helpers for the matrix sequencer.
package matrix_ctrl_pkg;

  localparam int A_W      = 8;
  localparam int X_W      = 24;
  localparam int SUM_W    = 21;
  localparam int LOAD_CNT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_COMPUTE,
    S_WAIT,
    S_FLUSH,
    S_DONE
  } state_e;

  // Address widths never collapse to zero bits for single-entry memories.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_res_pipe.sv
// Two-stage valid + {vec,coef} delay line: stage 1 enables the ALU, stage 2
// writes the ALU sum to result RAM at vec*NUM_COEF+coef.
module matrix_res_pipe
  import matrix_ctrl_pkg::*;
#(
  parameter int NUM_COEF = 8,
  parameter int V_W      = 2,
  parameter int A_AW     = 3,
  parameter int R_AW     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld_i,
  input  logic [V_W-1:0]  vec_i,
  input  logic [A_AW-1:0] coef_i,
  output logic            alu_en_o,
  output logic            res_we_o,
  output logic [R_AW-1:0] res_addr_o
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic [V_W-1:0]  vec_q;
  logic [A_AW-1:0] coef_q;
  logic [R_AW-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      vec_q    <= '0;
      coef_q   <= '0;
      addr_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], vld_i};
      vec_q    <= vec_i;
      coef_q   <= coef_i;
      // The captured vec is used, so the last write of a vector is correct
      // even after the FSM has already advanced to the next LOAD_X.
      addr_q   <= vld_pipe[1] ? R_AW'(int'(vec_q) * NUM_COEF + int'(coef_q)) : '0;
    end
  end

  assign alu_en_o   = vld_pipe[1];
  assign res_we_o   = vld_pipe[STAGES];
  assign res_addr_o = addr_q;

endmodule

// File: rtl/matrix_ctrl.sv
// Sequencer for the 9-tap multiply-sum ALU: loads three X words per vector,
// streams NUM_COEF coefficients, and writes every ALU sum to result RAM.
module matrix_ctrl
  import matrix_ctrl_pkg::*;
#(
  parameter int NUM_VEC  = 4,
  parameter int NUM_COEF = 8,
  parameter int X_AW     = clog2_min1(3 * NUM_VEC),
  parameter int A_AW     = clog2_min1(NUM_COEF),
  parameter int R_AW     = clog2_min1(NUM_VEC * NUM_COEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             x_rd_en,
  output logic [X_AW-1:0]  x_addr,
  input  logic [X_W-1:0]   x_rdata,
  output logic             a_rd_en,
  output logic [A_AW-1:0]  a_addr,
  input  logic [A_W-1:0]   a_rdata,
  output logic             alu_en,
  output logic [A_W-1:0]   a_input,
  output logic [X_W-1:0]   x_reg1,
  output logic [X_W-1:0]   x_reg2,
  output logic [X_W-1:0]   x_reg3,
  input  logic [SUM_W-1:0] alu_sum,
  output logic             res_we,
  output logic [R_AW-1:0]  res_addr,
  output logic [SUM_W-1:0] res_wdata
);

  localparam int V_W = clog2_min1(NUM_VEC);

  state_e              state_q;
  logic [1:0]          cnt_q;
  logic [V_W-1:0]      vec_q;
  logic                busy_q;
  logic                done_q;
  logic                x_rd_en_q;
  logic [X_AW-1:0]     x_addr_q;
  logic                a_rd_en_q;
  logic [A_AW-1:0]     a_addr_q;
  logic [2:0][X_W-1:0] x_reg_q;

  // Outputs are registered: each transition loads the strobes for the state
  // being entered. a_addr_q doubles as the coefficient counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x_rd_en_q <= 1'b0;
      x_addr_q  <= '0;
      a_rd_en_q <= 1'b0;
      a_addr_q  <= '0;
      x_reg_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_LOAD_X;
            cnt_q     <= '0;
            vec_q     <= '0;
            busy_q    <= 1'b1;
            x_rd_en_q <= 1'b1;
            x_addr_q  <= '0;
          end
        end
        S_LOAD_X: begin
          // Read data lags the strobe by one cycle, so cnt=k captures word k-1.
          case (cnt_q)
            2'd1:    x_reg_q[0] <= x_rdata;
            2'd2:    x_reg_q[1] <= x_rdata;
            2'd3:    x_reg_q[2] <= x_rdata;
            default: ;
          endcase
          if (cnt_q == 2'(LOAD_CNT)) begin
            state_q   <= S_COMPUTE;
            a_rd_en_q <= 1'b1;
            a_addr_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'(LOAD_CNT - 1)) begin
              x_rd_en_q <= 1'b0;
              x_addr_q  <= '0;
            end else begin
              x_addr_q  <= X_AW'(int'(vec_q) * LOAD_CNT + int'(cnt_q) + 1);
            end
          end
        end
        S_COMPUTE: begin
          if (a_addr_q == A_AW'(NUM_COEF - 1)) begin
            state_q   <= S_WAIT;
            a_rd_en_q <= 1'b0;
            a_addr_q  <= '0;
          end else begin
            a_addr_q  <= a_addr_q + A_AW'(1);
          end
        end
        S_WAIT: begin
          if (vec_q != V_W'(NUM_VEC - 1)) begin
            state_q   <= S_LOAD_X;
            vec_q     <= vec_q + V_W'(1);
            cnt_q     <= '0;
            x_rd_en_q <= 1'b1;
            x_addr_q  <= X_AW'((int'(vec_q) + 1) * LOAD_CNT);
          end else begin
            state_q   <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  matrix_res_pipe #(
    .NUM_COEF (NUM_COEF),
    .V_W      (V_W),
    .A_AW     (A_AW),
    .R_AW     (R_AW)
  ) u_res_pipe (
    .clk        (clk),
    .rst        (rst),
    .vld_i      (a_rd_en_q),
    .vec_i      (vec_q),
    .coef_i     (a_addr_q),
    .alu_en_o   (alu_en),
    .res_we_o   (res_we),
    .res_addr_o (res_addr)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign x_rd_en   = x_rd_en_q;
  assign x_addr    = x_addr_q;
  assign a_rd_en   = a_rd_en_q;
  assign a_addr    = a_addr_q;
  assign a_input   = a_rdata;
  assign x_reg1    = x_reg_q[0];
  assign x_reg2    = x_reg_q[1];
  assign x_reg3    = x_reg_q[2];
  assign res_wdata = alu_sum;

endmodule
